// File: rtl/wb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_master_if
// Bundles the three channels of wb_cmd_master into one interface:
//   cmd_*   : single-word command port (valid/ready), driven by the requester
//   rsp_*   : response port (valid/ready), consumed by the requester
//   wbm_*   : Wishbone pipelined-mode initiator signals
// Modports:
//   master : the bus initiator (wb_cmd_master)
//   slave  : the environment around it (requester + Wishbone slave)
// ---------------------------------------------------------------------------
interface wb_cmd_master_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;

    // response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;

    // Wishbone initiator
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_stall_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_stall_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_stall_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
// Wishbone pipelined-mode initiator. Turns one command from the cmd port into
// one Wishbone single-word transaction and returns the read data (or an error
// flag on timeout) on the rsp port. One transaction in flight at a time.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : wb_cmd_master_if.master (cmd_*, rsp_*, wbm_* signals)
// Parameters:
//   TIMEOUT : cycles from strobe assertion to ack before abort (>= 2)
//   TO_W    : timeout counter width, 2**TO_W > TIMEOUT
// Build option:
//   WBM_TIMEOUT_EN : when defined, builds the timeout counter and rsp_err
//                    path; otherwise REQ/WAIT wait for ack indefinitely and
//                    rsp_err is constant 0.
// All outputs are registered except cmd_ready, decoded from state == IDLE.
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_cmd_master_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    logic   ack_taken;

    // Elaboration-time parameter sanity checks
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT must be at least 2");
    end
    if ((TO_W < 32) && ((32'd1 << TO_W) <= TIMEOUT)) begin : g_bad_to_w
        $error("wb_cmd_master: TO_W too narrow for TIMEOUT");
    end

    // Command port is open only while no transaction is in flight
    assign bus.cmd_ready = (state == IDLE);

    // In REQ an ack only counts once the strobe is accepted (stall low)
    assign ack_taken = bus.wbm_ack_i && ((state == WAIT) || !bus.wbm_stall_i);

`ifdef WBM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            expired;

    // Counter value k-1 in the k-th bus cycle; last allowed cycle is TIMEOUT
    assign expired = (to_cnt == TO_W'(TIMEOUT - 1));
`endif

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            bus.wbm_sel_o <= '0;
            bus.wbm_adr_o <= '0;
            bus.wbm_dat_o <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_dat   <= '0;
            bus.rsp_err   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.wbm_we_o  <= bus.cmd_we;
                        bus.wbm_adr_o <= bus.cmd_adr;
                        bus.wbm_sel_o <= bus.cmd_sel;
                        bus.wbm_dat_o <= bus.cmd_we ? bus.cmd_dat : '0;
                        bus.wbm_cyc_o <= 1'b1;
                        bus.wbm_stb_o <= 1'b1;
`ifdef WBM_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                        state         <= REQ;
                    end
                end

                REQ, WAIT: begin
`ifdef WBM_TIMEOUT_EN
                    to_cnt <= to_cnt + TO_W'(1);
`endif
                    // An ack on the expiry cycle still completes normally
                    if (ack_taken) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_dat   <= bus.wbm_we_o ? '0 : bus.wbm_dat_i;
                        state         <= RESP;
                    end
`ifdef WBM_TIMEOUT_EN
                    else if (expired) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_dat   <= '0;
                        state         <= RESP;
                    end
`endif
                    else if ((state == REQ) && !bus.wbm_stall_i) begin
                        // Strobe accepted without ack: keep the cycle open
                        bus.wbm_stb_o <= 1'b0;
                        state         <= WAIT;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
// Directed bench for wb_cmd_master. Each transaction is described by its
// command, the slave's stall count, the ack delay after strobe acceptance,
// the read data and how long the requester holds off rsp_ready. A timeline
// model derives, for every cycle, what cyc/stb/rsp_valid/cmd_ready and the
// bus/response fields must be; a negedge compare process checks them.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TO_W    = 5;
    localparam int          NEVER   = 1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_cmd_master_if bus ();

    wb_cmd_master #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // expected values for the current cycle
    bit          chk_en = 1'b0;
    logic        e_cmd_ready, e_cyc, e_stb, e_rsp_valid, e_we, e_err;
    logic [31:0] e_adr, e_dat, e_rdat;
    logic [3:0]  e_sel;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h, required 0x%08h",
                     name, $time, act, exp);
        end
    endfunction

    // Single compare process against the timeline model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_cmd_ready));
            chk("cyc",       32'(bus.wbm_cyc_o), 32'(e_cyc));
            chk("stb",       32'(bus.wbm_stb_o), 32'(e_stb));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp_valid));
            if (e_cyc) begin
                chk("we",  32'(bus.wbm_we_o),  32'(e_we));
                chk("adr", bus.wbm_adr_o,      e_adr);
                chk("sel", 32'(bus.wbm_sel_o), 32'(e_sel));
                chk("dat_o", bus.wbm_dat_o,    e_dat);
            end
            if (e_rsp_valid) begin
                chk("rsp_dat", bus.rsp_dat,       e_rdat);
                chk("rsp_err", 32'(bus.rsp_err),  32'(e_err));
            end
        end
    end

    task automatic set_idle_exp();
        e_cmd_ready = 1'b1;
        e_cyc       = 1'b0;
        e_stb       = 1'b0;
        e_rsp_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic spurious_ack);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid   = 1'b0;
            bus.wbm_ack_i   = spurious_ack;
            bus.wbm_stall_i = 1'b0;
            bus.wbm_dat_i   = 32'h5555_AAAA;
            bus.rsp_ready   = 1'b0;
            set_idle_exp();
            @(posedge clk); #1;
        end
    endtask

    // One transaction; e_out is the bus cycle in which cyc is last high
    task automatic run_txn(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int stalls, input int ack_wait,
                           input logic [31:0] rdata, input int rdly,
                           output logic [31:0] got_dat, output logic got_err,
                           output int e_out);
        int   ack_cyc;
        int   e;
        int   stb_end;
        logic err;
        ack_cyc = stalls + 1 + ack_wait;
`ifdef WBM_TIMEOUT_EN
        err = (ack_cyc > int'(TIMEOUT));
        e   = err ? int'(TIMEOUT) : ack_cyc;
`else
        err = 1'b0;
        e   = ack_cyc;
`endif
        stb_end = (stalls + 1 < e) ? stalls + 1 : e;
        e_out   = e;
        got_dat = 'x;
        got_err = 1'bx;

        // cycle 0: command presented while idle
        bus.cmd_valid   = 1'b1;
        bus.cmd_we      = we;
        bus.cmd_adr     = adr;
        bus.cmd_dat     = dat;
        bus.cmd_sel     = sel;
        bus.wbm_stall_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_dat_i   = 32'hDEAD_BEEF;
        bus.rsp_ready   = 1'b0;
        set_idle_exp();
        e_we   = we;
        e_adr  = adr;
        e_sel  = sel;
        e_dat  = we ? dat : 32'h0;
        e_err  = err;
        e_rdat = (err || we) ? 32'h0 : rdata;
        @(posedge clk); #1;

        for (int k = 1; k <= e + 1 + rdly; k++) begin
            // scramble the command port to show the bus fields were latched
            bus.cmd_valid   = 1'b0;
            bus.cmd_we      = ~we;
            bus.cmd_adr     = ~adr;
            bus.cmd_dat     = ~dat;
            bus.cmd_sel     = ~sel;
            bus.wbm_stall_i = (k <= stalls);
            bus.wbm_ack_i   = (k == ack_cyc);
            bus.wbm_dat_i   = (k == ack_cyc) ? rdata : 32'hDEAD_BEEF;
            bus.rsp_ready   = (k == e + 1 + rdly);
            e_cmd_ready     = 1'b0;
            e_cyc           = (k <= e);
            e_stb           = (k <= stb_end);
            e_rsp_valid     = (k > e);
            if (k == e + 1) begin
                got_dat = bus.rsp_dat;
                got_err = bus.rsp_err;
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        set_idle_exp();
    endtask

    logic [31:0] gd;
    logic        ge;
    int          ge_cyc;

    initial begin
        rst             = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_we      = 1'b0;
        bus.cmd_adr     = 32'h0;
        bus.cmd_dat     = 32'h0;
        bus.cmd_sel     = 4'h0;
        bus.rsp_ready   = 1'b0;
        bus.wbm_dat_i   = 32'h0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_stall_i = 1'b0;
        set_idle_exp();

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_cyc",       32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb",       32'(bus.wbm_stb_o), 32'd0);
        chk("rst_we",        32'(bus.wbm_we_o),  32'd0);
        chk("rst_sel",       32'(bus.wbm_sel_o), 32'd0);
        chk("rst_adr",       bus.wbm_adr_o,      32'd0);
        chk("rst_dat_o",     bus.wbm_dat_o,      32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_dat",   bus.rsp_dat,        32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        rst    = 1'b1;
        chk_en = 1'b1;
        idle(2, 1'b0);

        // zero-wait write: response 2 cycles after accept, data 0
        run_txn(1'b1, 32'h3000_0020, 32'h1234_5678, 4'hF, 0, 0,
                32'hCAFE_F00D, 0, gd, ge, ge_cyc);
        chk("wr_last_cyc", 32'(ge_cyc), 32'd1);
        chk("wr_rsp_dat",  gd,          32'h0);
        chk("wr_rsp_err",  32'(ge),     32'd0);

        // 3 stalls, ack 2 cycles after strobe accepted
        run_txn(1'b0, 32'h3000_0020, 32'h7777_7777, 4'hF, 3, 2,
                32'hA5A5_0F0F, 0, gd, ge, ge_cyc);
        chk("rd_stall_last_cyc", 32'(ge_cyc), 32'd6);
        chk("rd_stall_rsp_dat",  gd,          32'hA5A5_0F0F);

        // rsp_ready held off 5 cycles
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, 0, 0,
                32'h0BAD_1DEA, 5, gd, ge, ge_cyc);
        chk("rd_hold_rsp_dat", gd, 32'h0BAD_1DEA);

        // back-to-back, no idle gap between commands
        run_txn(1'b1, 32'h3000_0024, 32'h0000_00C3, 4'h1, 1, 0,
                32'h1111_2222, 0, gd, ge, ge_cyc);
        run_txn(1'b0, 32'h3000_0028, 32'h0, 4'hC, 0, 1,
                32'h8765_4321, 0, gd, ge, ge_cyc);
        chk("b2b_rsp_dat", gd, 32'h8765_4321);

        // stray acks while idle must not produce a response
        idle(3, 1'b1);
        idle(1, 1'b0);

`ifdef WBM_TIMEOUT_EN
        // slave never acks: abort after TIMEOUT cycles
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, NEVER,
                32'hFFFF_FFFF, 1, gd, ge, ge_cyc);
        chk("to_last_cyc", 32'(ge_cyc), 32'd16);
        chk("to_rsp_err",  32'(ge),     32'd1);
        chk("to_rsp_dat",  gd,          32'h0);

        // following command proceeds normally
        run_txn(1'b1, 32'h3000_0020, 32'h0000_0001, 4'hF, 0, 0,
                32'h0, 0, gd, ge, ge_cyc);
        chk("after_to_err", 32'(ge), 32'd0);

        // ack in the expiry cycle wins
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 13,
                32'h5A5A_C3C3, 0, gd, ge, ge_cyc);
        chk("edge_last_cyc", 32'(ge_cyc), 32'd16);
        chk("edge_rsp_err",  32'(ge),     32'd0);
        chk("edge_rsp_dat",  gd,          32'h5A5A_C3C3);

        // expiry while still stalled
        run_txn(1'b1, 32'h3000_0030, 32'hFEED_0000, 4'hF, 20, 0,
                32'h0, 0, gd, ge, ge_cyc);
        chk("stall_to_err", 32'(ge), 32'd1);
        idle(1, 1'b0);
`endif

        // reset pulsed during WAIT
        bus.cmd_valid   = 1'b1;
        bus.cmd_we      = 1'b0;
        bus.cmd_adr     = 32'h3000_0020;
        bus.cmd_dat     = 32'h0;
        bus.cmd_sel     = 4'hF;
        bus.wbm_stall_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        set_idle_exp();
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        e_cmd_ready   = 1'b0;
        e_cyc         = 1'b1;
        e_stb         = 1'b1;
        e_we          = 1'b0;
        e_adr         = 32'h3000_0020;
        e_sel         = 4'hF;
        e_dat         = 32'h0;
        @(posedge clk); #1;
        e_stb = 1'b0;
        @(posedge clk); #1;
        #2;
        chk_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("arst_cyc",       32'(bus.wbm_cyc_o), 32'd0);
        chk("arst_stb",       32'(bus.wbm_stb_o), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        // late ack from the lost transaction
        idle(2, 1'b1);
        idle(1, 1'b0);

        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 0,
                32'h0F0F_A5A5, 0, gd, ge, ge_cyc);
        chk("post_rst_rsp_dat", gd, 32'h0F0F_A5A5);
        idle(2, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
